// File: rtl/matmul_stream_checker.sv
// matmul_stream_checker: compares expected and actual result-element streams (row-major)
// for one N x M matrix per test and keeps a pass/fail summary over NUM_TESTS tests.
// Optional MATMUL_CHK_TOL_EN adds a tol_i input: an element mismatches only when
// |exp - act| > tol. Without the macro the compare is exact and tol_i does not exist.
module matmul_stream_checker #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MAX_DIM    = 4,
  parameter int unsigned DIM_W      = 3,
  parameter int unsigned NUM_TESTS  = 8,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [DIM_W-1:0]      n_dim_i,
  input  logic [DIM_W-1:0]      m_dim_i,
  input  logic                  abort_i,
  input  logic                  exp_valid_i,
  output logic                  exp_ready_o,
  input  logic [DATA_WIDTH-1:0] exp_data_i,
  input  logic                  act_valid_i,
  output logic                  act_ready_o,
  input  logic [DATA_WIDTH-1:0] act_data_i,
`ifdef MATMUL_CHK_TOL_EN
  input  logic [DATA_WIDTH-1:0] tol_i,
`endif
  output logic                  busy_o,
  output logic                  cfg_err_o,
  output logic                  done_o,
  output logic                  pass_o,
  output logic [CNT_W-1:0]      err_count_o,
  output logic [DIM_W-1:0]      first_row_o,
  output logic [DIM_W-1:0]      first_col_o,
  output logic [DATA_WIDTH-1:0] first_exp_o,
  output logic [DATA_WIDTH-1:0] first_act_o,
  output logic [CNT_W-1:0]      test_idx_o,
  output logic [CNT_W-1:0]      fail_tests_o,
  output logic                  all_done_o
);

  localparam logic [DIM_W-1:0] DimOne   = DIM_W'(1);
  localparam logic [DIM_W-1:0] DimMax   = DIM_W'(MAX_DIM);
  localparam logic [CNT_W-1:0] CntOne   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CntMax   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CntTests = CNT_W'(NUM_TESTS);

  typedef enum logic [1:0] {StIdle, StRun, StReport, StFinished} state_e;

  state_e                state_q, state_d;
  logic [DIM_W-1:0]      n_q, n_d, m_q, m_d;
  logic [DIM_W-1:0]      row_q, row_d, col_q, col_d;
  logic [CNT_W-1:0]      err_q, err_d, err_next;
  logic [DIM_W-1:0]      frow_q, frow_d, fcol_q, fcol_d;
  logic [DATA_WIDTH-1:0] fexp_q, fexp_d, fact_q, fact_d;
  logic                  seen_q, seen_d;
  logic                  pass_q, pass_d;
  logic                  cfg_err_q, cfg_err_d;
  logic [CNT_W-1:0]      tidx_q, tidx_d, tidx_inc;
  logic [CNT_W-1:0]      fail_q, fail_d;

  logic dims_ok, accept, last_elem, mismatch;

  assign dims_ok = (n_dim_i != '0) && (n_dim_i <= DimMax) &&
                   (m_dim_i != '0) && (m_dim_i <= DimMax);
  // Join handshake; abort blocks acceptance of the pair offered in the same cycle.
  assign accept      = (state_q == StRun) && exp_valid_i && act_valid_i && !abort_i;
  assign exp_ready_o = accept;
  assign act_ready_o = accept;
  assign last_elem   = (row_q == n_q - DimOne) && (col_q == m_q - DimOne);

`ifdef MATMUL_CHK_TOL_EN
  logic [DATA_WIDTH-1:0] tol_q, tol_d;
  logic signed [DATA_WIDTH:0] diff;
  logic [DATA_WIDTH:0] mag;

  // Signed difference in one extra bit cannot overflow; its magnitude fits unsigned.
  always_comb begin
    diff     = $signed({exp_data_i[DATA_WIDTH-1], exp_data_i}) -
               $signed({act_data_i[DATA_WIDTH-1], act_data_i});
    mag      = diff[DATA_WIDTH] ? $unsigned(-diff) : $unsigned(diff);
    mismatch = mag > {1'b0, tol_q};
  end
`else
  assign mismatch = (exp_data_i != act_data_i);
`endif

  // Error count after the current cycle's acceptance, saturating.
  always_comb begin
    err_next = err_q;
    if (accept && mismatch && (err_q != CntMax)) begin
      err_next = err_q + CntOne;
    end
  end

  assign tidx_inc = (tidx_q != CntMax) ? tidx_q + CntOne : tidx_q;

  // Next-state and datapath updates.
  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    m_d       = m_q;
    row_d     = row_q;
    col_d     = col_q;
    err_d     = err_q;
    frow_d    = frow_q;
    fcol_d    = fcol_q;
    fexp_d    = fexp_q;
    fact_d    = fact_q;
    seen_d    = seen_q;
    pass_d    = pass_q;
    cfg_err_d = 1'b0;
    tidx_d    = tidx_q;
    fail_d    = fail_q;
`ifdef MATMUL_CHK_TOL_EN
    tol_d     = tol_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          if (dims_ok) begin
            n_d     = n_dim_i;
            m_d     = m_dim_i;
            row_d   = '0;
            col_d   = '0;
            err_d   = '0;
            frow_d  = '0;
            fcol_d  = '0;
            fexp_d  = '0;
            fact_d  = '0;
            seen_d  = 1'b0;
            pass_d  = 1'b0;
`ifdef MATMUL_CHK_TOL_EN
            tol_d   = tol_i;
`endif
            state_d = StRun;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      StRun: begin
        if (abort_i) begin
          state_d = StIdle;
        end else if (accept) begin
          err_d = err_next;
          if (mismatch && !seen_q) begin
            frow_d = row_q;
            fcol_d = col_q;
            fexp_d = exp_data_i;
            fact_d = act_data_i;
            seen_d = 1'b1;
          end
          if (col_q == m_q - DimOne) begin
            col_d = '0;
            row_d = row_q + DimOne;
          end else begin
            col_d = col_q + DimOne;
          end
          if (last_elem) begin
            pass_d  = (err_next == '0);
            state_d = StReport;
          end
        end
      end
      StReport: begin
        tidx_d = tidx_inc;
        if (!pass_q && (fail_q != CntMax)) begin
          fail_d = fail_q + CntOne;
        end
        state_d = (tidx_inc >= CntTests) ? StFinished : StIdle;
      end
      StFinished: begin
        state_d = StFinished;
      end
      default: state_d = StIdle;
    endcase
  end

  // State register with synchronous active-high reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      n_q       <= '0;
      m_q       <= '0;
      row_q     <= '0;
      col_q     <= '0;
      err_q     <= '0;
      frow_q    <= '0;
      fcol_q    <= '0;
      fexp_q    <= '0;
      fact_q    <= '0;
      seen_q    <= 1'b0;
      pass_q    <= 1'b0;
      cfg_err_q <= 1'b0;
      tidx_q    <= '0;
      fail_q    <= '0;
`ifdef MATMUL_CHK_TOL_EN
      tol_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      n_q       <= n_d;
      m_q       <= m_d;
      row_q     <= row_d;
      col_q     <= col_d;
      err_q     <= err_d;
      frow_q    <= frow_d;
      fcol_q    <= fcol_d;
      fexp_q    <= fexp_d;
      fact_q    <= fact_d;
      seen_q    <= seen_d;
      pass_q    <= pass_d;
      cfg_err_q <= cfg_err_d;
      tidx_q    <= tidx_d;
      fail_q    <= fail_d;
`ifdef MATMUL_CHK_TOL_EN
      tol_q     <= tol_d;
`endif
    end
  end

  assign busy_o       = (state_q == StRun);
  assign done_o       = (state_q == StReport);
  assign all_done_o   = (state_q == StFinished);
  assign cfg_err_o    = cfg_err_q;
  assign pass_o       = pass_q;
  assign err_count_o  = err_q;
  assign first_row_o  = frow_q;
  assign first_col_o  = fcol_q;
  assign first_exp_o  = fexp_q;
  assign first_act_o  = fact_q;
  assign test_idx_o   = tidx_q;
  assign fail_tests_o = fail_q;

endmodule

// File: tb/tb_matmul_stream_checker.sv
// Bench for matmul_stream_checker: scenario tasks with a scoreboard of expected per-test
// results, pushed when a matrix is loaded and popped when the DUT reports done.
`timescale 1ns/1ps
module tb_matmul_stream_checker;
  localparam int DW = 32;
  localparam int DIM_W = 3;
  localparam int CNT_W = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1, start = 1'b0, abort = 1'b0;
  logic [DIM_W-1:0] n_dim = '0, m_dim = '0;
  logic exp_valid = 1'b0, act_valid = 1'b0;
  logic [DW-1:0] exp_data = '0, act_data = '0;
  logic exp_ready, act_ready, busy, cfg_err, done, pass, all_done;
  logic [CNT_W-1:0] err_count, test_idx, fail_tests;
  logic [DIM_W-1:0] first_row, first_col;
  logic [DW-1:0] first_exp, first_act;
`ifdef MATMUL_CHK_TOL_EN
  logic [DW-1:0] tol = '0;
`endif

  int errors = 0;
  int checks = 0;
  logic [DW-1:0] exp_mem[16];
  logic [DW-1:0] act_mem[16];

  typedef struct packed {
    logic [CNT_W-1:0] err;
    logic             pass;
    logic [DIM_W-1:0] frow;
    logic [DIM_W-1:0] fcol;
    logic [DW-1:0]    fexp;
    logic [DW-1:0]    fact;
  } score_t;

  typedef struct {
    int     acc;
    int     cycles;
    int     bad_ready;
    bit     early_done;
    bit     done_seen;
    bit     done_one;
    score_t got;
  } run_t;

  score_t sb_q[$];

  matmul_stream_checker dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .n_dim_i(n_dim), .m_dim_i(m_dim),
    .abort_i(abort), .exp_valid_i(exp_valid), .exp_ready_o(exp_ready), .exp_data_i(exp_data),
    .act_valid_i(act_valid), .act_ready_o(act_ready), .act_data_i(act_data),
`ifdef MATMUL_CHK_TOL_EN
    .tol_i(tol),
`endif
    .busy_o(busy), .cfg_err_o(cfg_err), .done_o(done), .pass_o(pass),
    .err_count_o(err_count), .first_row_o(first_row), .first_col_o(first_col),
    .first_exp_o(first_exp), .first_act_o(first_act), .test_idx_o(test_idx),
    .fail_tests_o(fail_tests), .all_done_o(all_done)
  );

  function automatic bit model_mismatch(input logic [DW-1:0] e, input logic [DW-1:0] a);
`ifdef MATMUL_CHK_TOL_EN
    longint d;
    d = longint'($signed(e)) - longint'($signed(a));
    if (d < 0) d = -d;
    return d > longint'(tol);
`else
    return e !== a;
`endif
  endfunction

  // Reference result of one test, computed from the loaded stimulus.
  task automatic push_expected(input int n, input int m);
    score_t s;
    s = '0;
    for (int k = 0; k < n * m; k++) begin
      if (model_mismatch(exp_mem[k], act_mem[k])) begin
        if (s.err == 0) begin
          s.frow = DIM_W'(k / m);
          s.fcol = DIM_W'(k % m);
          s.fexp = exp_mem[k];
          s.fact = act_mem[k];
        end
        s.err = s.err + 1'b1;
      end
    end
    s.pass = (s.err == 0);
    sb_q.push_back(s);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Starts a test and streams n*m pairs; stop_kind 1 = abort, 2 = rst at pair index stop_at.
  task automatic drive_matrix(input int n, input int m, input bit gap, input int stop_at,
                              input int stop_kind, output run_t r);
    int k, cyc, total;
    bit acc;
    r.acc = 0; r.cycles = 0; r.bad_ready = 0;
    r.early_done = 0; r.done_seen = 0; r.done_one = 0; r.got = '0;
    total = n * m;
    @(negedge clk);
    start = 1'b1;
    n_dim = DIM_W'(n);
    m_dim = DIM_W'(m);
    @(negedge clk);
    start = 1'b0;
    k = 0;
    cyc = 0;
    while (k < total && cyc < 200) begin
      if (done) r.early_done = 1;
      exp_valid = gap ? (cyc % 2 == 0) : 1'b1;
      act_valid = 1'b1;
      exp_data = exp_mem[k];
      act_data = act_mem[k];
      if (k == stop_at) begin
        if (stop_kind == 1) abort = 1'b1;
        else rst = 1'b1;
      end
      #1;
      acc = exp_ready && act_ready;
      if ((exp_ready || act_ready) && !(exp_valid && act_valid)) r.bad_ready++;
      if (exp_ready !== act_ready) r.bad_ready++;
      @(posedge clk);
      cyc++;
      if (acc) k++;
      @(negedge clk);
      if (abort || rst) begin
        abort = 1'b0;
        rst = 1'b0;
        exp_valid = 1'b0;
        act_valid = 1'b0;
        r.acc = k;
        r.cycles = cyc;
        return;
      end
    end
    exp_valid = 1'b0;
    act_valid = 1'b0;
    r.acc = k;
    r.cycles = cyc;
    r.done_seen = done;
    r.got = {err_count, pass, first_row, first_col, first_exp, first_act};
    @(negedge clk);
    r.done_one = !done;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    exp_valid = 1'b1;
    act_valid = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, cfg_err, done, pass, all_done, exp_ready, act_ready} !== 7'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b want 0000000",
               {busy, cfg_err, done, pass, all_done, exp_ready, act_ready});
    end
    checks++;
    if ({err_count, test_idx, fail_tests, first_row, first_col, first_exp, first_act} !== '0) begin
      errors++;
      $display("FAIL reset_fields: got %h want 0",
               {err_count, test_idx, fail_tests, first_row, first_col, first_exp, first_act});
    end
    exp_valid = 1'b0;
    act_valid = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_exact_pass();
    run_t r;
    score_t s;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      exp_mem[k] = DW'(k + 1);
      act_mem[k] = DW'(k + 1);
    end
    push_expected(2, 2);
    drive_matrix(2, 2, 1'b0, -1, 0, r);
    s = sb_q.pop_front();
    checks++;
    if (r.got !== s) begin
      errors++; $display("FAIL pass2x2_result: got %h want %h", r.got, s);
    end
    checks++;
    if (r.cycles !== 4 || r.acc !== 4) begin
      errors++; $display("FAIL pass2x2_cycles: got %0d/%0d want 4/4", r.cycles, r.acc);
    end
    checks++;
    if (!r.done_seen || !r.done_one || r.early_done) begin
      errors++;
      $display("FAIL pass2x2_done: got seen=%0b one=%0b early=%0b want 1 1 0",
               r.done_seen, r.done_one, r.early_done);
    end
    checks++;
    if (test_idx !== 1 || fail_tests !== 0) begin
      errors++; $display("FAIL pass2x2_counts: got %0d/%0d want 1/0", test_idx, fail_tests);
    end
  endtask

  task automatic test_mismatch();
    run_t r;
    score_t s;
    do_reset();
    for (int k = 0; k < 12; k++) begin
      exp_mem[k] = DW'(100 + k);
      act_mem[k] = DW'(100 + k);
    end
    exp_mem[6] = 7;
    act_mem[6] = 9;
    act_mem[11] = exp_mem[11] + 5;
    push_expected(3, 4);
    drive_matrix(3, 4, 1'b0, -1, 0, r);
    s = sb_q.pop_front();
    checks++;
    if (r.got !== s) begin
      errors++; $display("FAIL mism3x4_result: got %h want %h", r.got, s);
    end
    checks++;
    if (r.got.err !== 2 || r.got.frow !== 1 || r.got.fcol !== 2 ||
        r.got.fexp !== 7 || r.got.fact !== 9 || r.got.pass !== 1'b0) begin
      errors++; $display("FAIL mism3x4_first: got %h want err=2 (1,2) 7/9 pass=0", r.got);
    end
    checks++;
    if (fail_tests !== 1 || test_idx !== 1 || !r.done_seen) begin
      errors++;
      $display("FAIL mism3x4_counts: got fail=%0d idx=%0d done=%0b want 1 1 1",
               fail_tests, test_idx, r.done_seen);
    end
  endtask

  task automatic test_exp_gap();
    run_t r;
    score_t s;
    do_reset();
    for (int k = 0; k < 16; k++) begin
      exp_mem[k] = $urandom;
      act_mem[k] = exp_mem[k];
    end
    act_mem[9] = act_mem[9] ^ 32'h0000_0100;
    push_expected(4, 4);
    drive_matrix(4, 4, 1'b1, -1, 0, r);
    s = sb_q.pop_front();
    checks++;
    if (r.got !== s) begin
      errors++; $display("FAIL gap4x4_result: got %h want %h", r.got, s);
    end
    checks++;
    if (r.acc !== 16 || r.cycles !== 31 || r.bad_ready !== 0) begin
      errors++;
      $display("FAIL gap4x4_flow: got acc=%0d cyc=%0d bad=%0d want 16 31 0",
               r.acc, r.cycles, r.bad_ready);
    end
    checks++;
    if (!r.done_seen || r.early_done) begin
      errors++;
      $display("FAIL gap4x4_done: got seen=%0b early=%0b want 1 0", r.done_seen, r.early_done);
    end
  endtask

  task automatic test_cfg_err();
    logic [DIM_W-1:0] bad_n[2] = '{3'd0, 3'd2};
    logic [DIM_W-1:0] bad_m[2] = '{3'd2, 3'd5};
    do_reset();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      start = 1'b1;
      n_dim = bad_n[i];
      m_dim = bad_m[i];
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (cfg_err !== 1'b1 || busy !== 1'b0) begin
        errors++; $display("FAIL cfg_err_pulse%0d: got %0b/%0b want 1/0", i, cfg_err, busy);
      end
      @(negedge clk);
      checks++;
      if (cfg_err !== 1'b0 || busy !== 1'b0) begin
        errors++; $display("FAIL cfg_err_width%0d: got %0b/%0b want 0/0", i, cfg_err, busy);
      end
    end
    checks++;
    if (test_idx !== 0) begin
      errors++; $display("FAIL cfg_err_idx: got %0d want 0", test_idx);
    end
  endtask

  task automatic test_abort();
    run_t r;
    score_t s;
    bit saw_done;
    do_reset();
    for (int k = 0; k < 9; k++) begin
      exp_mem[k] = $urandom;
      act_mem[k] = exp_mem[k] + 1;
    end
    drive_matrix(3, 3, 1'b0, 5, 1, r);
    saw_done = 0;
    repeat (3) begin
      if (done || busy) saw_done = 1;
      @(negedge clk);
    end
    checks++;
    if (r.acc !== 5 || saw_done || test_idx !== 0 || fail_tests !== 0) begin
      errors++;
      $display("FAIL abort_effect: got acc=%0d done/busy=%0b idx=%0d fail=%0d want 5 0 0 0",
               r.acc, saw_done, test_idx, fail_tests);
    end
    for (int k = 0; k < 9; k++) act_mem[k] = exp_mem[k];
    push_expected(3, 3);
    drive_matrix(3, 3, 1'b0, -1, 0, r);
    s = sb_q.pop_front();
    checks++;
    if (r.got !== s || pass !== 1'b1) begin
      errors++; $display("FAIL abort_retest: got %h pass=%0b want %h pass=1", r.got, pass, s);
    end
    checks++;
    if (test_idx !== 1) begin
      errors++; $display("FAIL abort_idx: got %0d want 1", test_idx);
    end
  endtask

  task automatic test_rst_mid();
    run_t r;
    score_t s;
    do_reset();
    for (int k = 0; k < 9; k++) begin
      exp_mem[k] = $urandom;
      act_mem[k] = exp_mem[k] ^ 32'h1;
    end
    push_expected(2, 2);
    drive_matrix(2, 2, 1'b0, -1, 0, r);
    s = sb_q.pop_front();
    checks++;
    if (r.got !== s || fail_tests !== 1) begin
      errors++; $display("FAIL rstmid_pre: got %h fail=%0d want %h fail=1", r.got, fail_tests, s);
    end
    drive_matrix(3, 3, 1'b0, 4, 2, r);
    checks++;
    if ({busy, cfg_err, done, pass, all_done, err_count, test_idx, fail_tests,
         first_row, first_col, first_exp, first_act} !== '0) begin
      errors++;
      $display("FAIL rstmid_clear: got busy=%0b pass=%0b err=%0d idx=%0d fail=%0d fe=%h fa=%h want 0",
               busy, pass, err_count, test_idx, fail_tests, first_exp, first_act);
    end
  endtask

  task automatic test_all_done();
    run_t r;
    score_t s;
    int n, m;
    do_reset();
    for (int t = 0; t < 8; t++) begin
      n = 1 + int'($urandom_range(3));
      m = 1 + int'($urandom_range(3));
      for (int k = 0; k < n * m; k++) begin
        exp_mem[k] = $urandom;
        act_mem[k] = exp_mem[k];
      end
      if (t == 1 || t == 4 || t == 6) begin
        int j;
        j = int'($urandom_range(n * m - 1));
        act_mem[j] = act_mem[j] ^ 32'h8000_0001;
      end
      push_expected(n, m);
      drive_matrix(n, m, 1'b0, -1, 0, r);
      s = sb_q.pop_front();
      checks++;
      if (r.got !== s || !r.done_seen) begin
        errors++;
        $display("FAIL run8_t%0d: got %h done=%0b want %h done=1", t, r.got, r.done_seen, s);
      end
    end
    checks++;
    if (all_done !== 1'b1 || fail_tests !== 3 || test_idx !== 8) begin
      errors++;
      $display("FAIL run8_summary: got all=%0b fail=%0d idx=%0d want 1 3 8",
               all_done, fail_tests, test_idx);
    end
    @(negedge clk);
    start = 1'b1;
    n_dim = 2;
    m_dim = 2;
    exp_valid = 1'b1;
    act_valid = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || exp_ready !== 1'b0 || act_ready !== 1'b0 || all_done !== 1'b1 ||
        test_idx !== 8) begin
      errors++;
      $display("FAIL finished_ignore: got busy=%0b rdy=%0b%0b all=%0b idx=%0d want 0 00 1 8",
               busy, exp_ready, act_ready, all_done, test_idx);
    end
    exp_valid = 1'b0;
    act_valid = 1'b0;
  endtask

`ifdef MATMUL_CHK_TOL_EN
  task automatic test_tol();
    run_t r;
    score_t s;
    logic [DW-1:0] ev[3] = '{32'd10, 32'd10, 32'd12};
    logic [DW-1:0] av[3] = '{32'd12, 32'd13, 32'd10};
    logic          pv[3] = '{1'b1, 1'b0, 1'b1};
    do_reset();
    tol = 2;
    for (int i = 0; i < 3; i++) begin
      exp_mem[0] = ev[i];
      act_mem[0] = av[i];
      push_expected(1, 1);
      drive_matrix(1, 1, 1'b0, -1, 0, r);
      s = sb_q.pop_front();
      checks++;
      if (r.got !== s || r.got.pass !== pv[i]) begin
        errors++;
        $display("FAIL tol_case%0d: got %h pass=%0b want %h pass=%0b",
                 i, r.got, r.got.pass, s, pv[i]);
      end
    end
    tol = 0;
  endtask
`endif

  initial begin
    test_reset();
    test_exact_pass();
    test_mismatch();
    test_exp_gap();
    test_cfg_err();
    test_abort();
    test_rst_mid();
    test_all_done();
`ifdef MATMUL_CHK_TOL_EN
    test_tol();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
